// File: rtl/tiled_load_engine.sv
// tiled_load_engine
// LOAD_V / LOAD_M executor. It reads beats from DRAM, packs them into tiles,
// zero-pads the final tile and hands each tile to the buffer controller over a
// ready/valid handshake. Bad commands (unknown opcode or zero elements) finish
// immediately with error=1 and generate no traffic.
// Optional feature macro: LOAD_EXEC_PERF_EN (busy/stall performance counters).
module tiled_load_engine #(
   parameter int DATA_WIDTH      = 8,
   parameter int TILE_WIDTH      = 256,
   parameter int MEM_WIDTH       = 64,
   parameter int ADDR_WIDTH      = 24,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4:0]            opcode,
   input  logic [4:0]            dest_buffer_id,
   input  logic [9:0]            length_or_cols,
   input  logic [9:0]            rows,
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   input  logic                  mem_rsp_valid,
   input  logic [MEM_WIDTH-1:0]  mem_rsp_data,
   output logic                  buf_write_valid,
   input  logic                  buf_write_ready,
   output logic                  buf_write_is_matrix,
   output logic [4:0]            buf_write_buffer_id,
   output logic [TILE_WIDTH-1:0] buf_write_tile,
   output logic                  buf_write_last,
   output logic [31:0]           perf_busy_cycles,
   output logic [31:0]           perf_stall_cycles
);

   localparam int TILE_BEATS = TILE_WIDTH / MEM_WIDTH;
   localparam int TILE_ELEMS = TILE_WIDTH / DATA_WIDTH;
   localparam int BEAT_BYTES = MEM_WIDTH / 8;
   localparam int IF_W       = $clog2(MAX_OUTSTANDING + 1);
   localparam int TB_W       = $clog2(TILE_BEATS + 1);
   localparam logic [4:0] OP_LOAD_V = 5'h01;
   localparam logic [4:0] OP_LOAD_M = 5'h02;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_EMIT, S_DONE} state_t;

   state_t state_reg, state_next;

   logic                  is_matrix_reg;
   logic [4:0]            buffer_id_reg;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [31:0]           beats_total_reg;
   logic [31:0]           tail_elems_reg;
   logic [31:0]           req_cnt_reg;
   logic [31:0]           rsp_cnt_reg;
   logic [IF_W-1:0]       in_flight_reg;
   logic [TB_W-1:0]       beats_in_tile_reg;
   logic [TILE_WIDTH-1:0] tile_reg;
   logic                  last_reg;
   logic                  error_reg;

   logic [19:0] n_calc;
   logic [31:0] beats_calc;
   logic [31:0] tail_mod;
   logic [31:0] tail_calc;
   logic        cmd_ok;
   logic        issue_ok;
   logic        req_fire;
   logic        rsp_fire;
   logic        rsp_final;
   logic        tile_full;

   // Decode the command on the input pins; only used when start is sampled in IDLE.
   always_comb begin
      n_calc     = (opcode == OP_LOAD_M) ? (20'(rows) * 20'(length_or_cols))
                                         : 20'(length_or_cols);
      beats_calc = (32'(n_calc) * 32'(DATA_WIDTH) + 32'(MEM_WIDTH - 1)) / 32'(MEM_WIDTH);
      tail_mod   = 32'(n_calc) % 32'(TILE_ELEMS);
      // Number of live elements in the final tile; a zero remainder means a full tile.
      tail_calc  = (tail_mod == 32'd0) ? 32'(TILE_ELEMS) : tail_mod;
      cmd_ok     = ((opcode == OP_LOAD_V) || (opcode == OP_LOAD_M)) && (n_calc != 20'd0);
   end

   // Request issue gating: the outstanding window never exceeds the room left in the tile,
   // so a tile fills with no reads in flight and responses never arrive during EMIT.
   always_comb begin
      issue_ok  = (state_reg == S_RUN)
               && (req_cnt_reg < beats_total_reg)
               && (32'(in_flight_reg) < 32'(MAX_OUTSTANDING))
               && ((32'(in_flight_reg) + 32'(beats_in_tile_reg)) < 32'(TILE_BEATS));
      req_fire  = issue_ok && mem_req_ready;
      // Responses outside RUN (stale data after a reset) are dropped.
      rsp_fire  = (state_reg == S_RUN) && mem_rsp_valid && (in_flight_reg != '0);
      rsp_final = rsp_fire && ((rsp_cnt_reg + 32'd1) == beats_total_reg);
      tile_full = rsp_fire && ((32'(beats_in_tile_reg) + 32'd1) == 32'(TILE_BEATS));
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= S_IDLE;
      else     state_reg <= state_next;
   end

   // FSM next-state and control outputs.
   always_comb begin
      state_next          = state_reg;
      busy                = 1'b0;
      done                = 1'b0;
      error               = 1'b0;
      buf_write_valid     = 1'b0;
      buf_write_is_matrix = 1'b0;
      buf_write_buffer_id = 5'd0;
      buf_write_last      = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start) state_next = cmd_ok ? S_RUN : S_DONE;
         end
         S_RUN: begin
            busy = 1'b1;
            if (rsp_final || tile_full) state_next = S_EMIT;
         end
         S_EMIT: begin
            busy                = 1'b1;
            buf_write_valid     = 1'b1;
            buf_write_is_matrix = is_matrix_reg;
            buf_write_buffer_id = buffer_id_reg;
            buf_write_last      = last_reg;
            if (buf_write_ready) state_next = last_reg ? S_DONE : S_RUN;
         end
         S_DONE: begin
            done       = 1'b1;
            error      = error_reg;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign mem_req_valid = issue_ok;
   assign mem_req_addr  = addr_reg + ADDR_WIDTH'(req_cnt_reg * 32'(BEAT_BYTES));

   // Command latch, beat/credit counters and tile packing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         is_matrix_reg     <= 1'b0;
         buffer_id_reg     <= 5'd0;
         addr_reg          <= '0;
         beats_total_reg   <= 32'd0;
         tail_elems_reg    <= 32'd0;
         req_cnt_reg       <= 32'd0;
         rsp_cnt_reg       <= 32'd0;
         in_flight_reg     <= '0;
         beats_in_tile_reg <= '0;
         tile_reg          <= '0;
         last_reg          <= 1'b0;
         error_reg         <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  is_matrix_reg     <= (opcode == OP_LOAD_M);
                  buffer_id_reg     <= dest_buffer_id;
                  addr_reg          <= addr;
                  beats_total_reg   <= beats_calc;
                  tail_elems_reg    <= tail_calc;
                  req_cnt_reg       <= 32'd0;
                  rsp_cnt_reg       <= 32'd0;
                  in_flight_reg     <= '0;
                  beats_in_tile_reg <= '0;
                  tile_reg          <= '0;
                  last_reg          <= 1'b0;
                  error_reg         <= !cmd_ok;
               end
            end
            S_RUN: begin
               if (req_fire) req_cnt_reg <= req_cnt_reg + 32'd1;
               in_flight_reg <= in_flight_reg + IF_W'(req_fire) - IF_W'(rsp_fire);
               if (rsp_fire) begin
                  for (int b = 0; b < TILE_BEATS; b++) begin
                     if (32'(beats_in_tile_reg) == 32'(b))
                        tile_reg[b*MEM_WIDTH +: MEM_WIDTH] <= mem_rsp_data;
                  end
                  beats_in_tile_reg <= beats_in_tile_reg + TB_W'(1);
                  rsp_cnt_reg       <= rsp_cnt_reg + 32'd1;
                  if (rsp_final) last_reg <= 1'b1;
               end
            end
            S_EMIT: begin
               if (buf_write_ready) begin
                  tile_reg          <= '0;
                  beats_in_tile_reg <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Final-tile padding: elements past N are forced to zero, including a partial final beat.
   genvar gi;
   generate
      for (gi = 0; gi < TILE_ELEMS; gi++) begin : g_mask
         assign buf_write_tile[gi*DATA_WIDTH +: DATA_WIDTH] =
            (!last_reg || (32'(gi) < tail_elems_reg)) ? tile_reg[gi*DATA_WIDTH +: DATA_WIDTH]
                                                       : {DATA_WIDTH{1'b0}};
      end
   endgenerate

`ifdef LOAD_EXEC_PERF_EN
   logic [31:0] perf_busy_reg;
   logic [31:0] perf_stall_reg;

   // Saturating busy and write-stall counters; cleared by an accepted start, held after done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_busy_reg  <= 32'd0;
         perf_stall_reg <= 32'd0;
      end else if ((state_reg == S_IDLE) && start) begin
         perf_busy_reg  <= 32'd0;
         perf_stall_reg <= 32'd0;
      end else begin
         if (busy && (perf_busy_reg != 32'hFFFF_FFFF))
            perf_busy_reg <= perf_busy_reg + 32'd1;
         if ((state_reg == S_EMIT) && !buf_write_ready && (perf_stall_reg != 32'hFFFF_FFFF))
            perf_stall_reg <= perf_stall_reg + 32'd1;
      end
   end

   assign perf_busy_cycles  = perf_busy_reg;
   assign perf_stall_cycles = perf_stall_reg;
`else
   assign perf_busy_cycles  = 32'd0;
   assign perf_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_tiled_load_engine.sv
// Testbench for tiled_load_engine: table of commands with hand-computed beat and
// tile counts, a DRAM model that answers reads out of a byte pattern, plus hand
// sequences for write backpressure and reset in the middle of a command.
`timescale 1ns/1ps
module tb_tiled_load_engine;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [4:0]   opcode = 5'd0;
   logic [4:0]   dest_buffer_id = 5'd0;
   logic [9:0]   length_or_cols = 10'd0;
   logic [9:0]   rows = 10'd0;
   logic [23:0]  addr = 24'd0;
   logic         busy, done, error;
   logic         mem_req_valid;
   logic         mem_req_ready = 1'b0;
   logic [23:0]  mem_req_addr;
   logic         mem_rsp_valid = 1'b0;
   logic [63:0]  mem_rsp_data = 64'd0;
   logic         buf_write_valid;
   logic         buf_write_ready = 1'b0;
   logic         buf_write_is_matrix;
   logic [4:0]   buf_write_buffer_id;
   logic [255:0] buf_write_tile;
   logic         buf_write_last;
   logic [31:0]  perf_busy_cycles, perf_stall_cycles;

   tiled_load_engine dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode),
      .dest_buffer_id(dest_buffer_id), .length_or_cols(length_or_cols), .rows(rows),
      .addr(addr), .busy(busy), .done(done), .error(error),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .buf_write_valid(buf_write_valid), .buf_write_ready(buf_write_ready),
      .buf_write_is_matrix(buf_write_is_matrix), .buf_write_buffer_id(buf_write_buffer_id),
      .buf_write_tile(buf_write_tile), .buf_write_last(buf_write_last),
      .perf_busy_cycles(perf_busy_cycles), .perf_stall_cycles(perf_stall_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  op;
      logic [9:0]  len;
      logic [9:0]  rws;
      logic [23:0] base;
      logic [4:0]  bid;
      int          n;
      int          beats;
      int          tiles;
      bit          err;
   } vec_t;

   int          tests = 0;
   int          fails = 0;
   logic [23:0] exp_base = 24'd0;
   int          req_idx = 0;
   int          stale_inject = 0;
   logic [23:0] pending[$];

   function automatic logic [7:0] mem_byte(input logic [23:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
   endfunction

   function automatic logic [63:0] beat_data(input logic [23:0] a);
      logic [63:0] d;
      d = '0;
      for (int i = 0; i < 8; i++) d[i*8 +: 8] = mem_byte(a + 24'(i));
      return d;
   endfunction

   // Element e of tile t is the byte at base+t*32+e, or zero past the command length.
   function automatic logic [255:0] exp_tile(input int t, input int n, input logic [23:0] base);
      logic [255:0] r;
      int g;
      r = '0;
      for (int e = 0; e < 32; e++) begin
         g = t * 32 + e;
         if (g < n) r[e*8 +: 8] = mem_byte(base + 24'(g));
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // DRAM model: accepts requests with random ready, answers in order with random gaps.
   initial begin : responder
      forever begin
         @(negedge clk);
         mem_rsp_valid = 1'b0;
         mem_rsp_data  = 64'd0;
         if (rst) begin
            pending.delete();
         end else if (stale_inject > 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 64'hDEAD_BEEF_CAFE_F00D;
            stale_inject--;
         end else if ((pending.size() > 0) && ($urandom_range(0, 3) != 0)) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = beat_data(pending.pop_front());
         end
         mem_req_ready = ($urandom_range(0, 3) != 0);
         if (mem_req_valid && mem_req_ready) begin
            check($sformatf("req_addr[%0d]", req_idx), 256'(mem_req_addr),
                  256'(24'(exp_base + 24'(req_idx * 8))));
            pending.push_back(mem_req_addr);
            req_idx++;
         end
      end
   end

   task automatic run_cmd(input vec_t v, input int stall_tile, input int stall_cycles, input bit poke);
      int t, cyc, busy_cnt, stall_left, exp_stall;
      bit seen, acc_last;
      logic [255:0] snap;
      exp_base = v.base;
      req_idx  = 0;
      @(negedge clk);
      start = 1'b1; opcode = v.op; dest_buffer_id = v.bid;
      length_or_cols = v.len; rows = v.rws; addr = v.base;
      @(negedge clk);
      start = 1'b0;
      if (v.err) begin
         bit quiet;
         check("err_done_error_busy", 256'({done, error, busy}), 256'(3'b110));
         quiet = 1'b1;
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || mem_req_valid || buf_write_valid) quiet = 1'b0;
         end
         check("err_no_traffic", 256'(quiet), 256'(1'b1));
         check("err_req_count", 256'(req_idx), 256'(0));
         $display("[TB] cmd op=%h n=%0d error command finished", v.op, v.n);
         return;
      end
      t = 0; cyc = 0; busy_cnt = 0; stall_left = 0; seen = 0; acc_last = 0; snap = '0;
      while (1) begin
         if (acc_last) begin
            check("done_after_last", 256'({done, error, busy}), 256'(3'b100));
            break;
         end
         if (done) begin
            check("early_done_tiles", 256'(t), 256'(v.tiles));
            break;
         end
         if (cyc >= 3000) begin
            fails++; tests++;
            $display("FAIL timeout got=%0d tiles want=%0d", t, v.tiles);
            break;
         end
         busy_cnt++; cyc++;
         if (poke && (cyc == 2)) begin
            start = 1'b1; opcode = 5'h03; dest_buffer_id = 5'h1F; length_or_cols = 10'd7;
         end
         if (buf_write_valid) begin
            if (!seen) begin
               check($sformatf("tile[%0d]", t), buf_write_tile, exp_tile(t, v.n, v.base));
               check($sformatf("meta[%0d]", t),
                     256'({buf_write_is_matrix, buf_write_buffer_id, buf_write_last}),
                     256'({(v.op == 5'h02), v.bid, (t == v.tiles - 1)}));
               seen = 1'b1;
               snap = buf_write_tile;
               stall_left = (t == stall_tile) ? stall_cycles : 0;
            end else begin
               check("stall_stable", 256'({buf_write_tile, mem_req_valid}), 256'({snap, 1'b0}));
            end
            if (stall_left > 0) begin
               buf_write_ready = 1'b0;
               stall_left--;
            end else begin
               buf_write_ready = 1'b1;
               if (t == v.tiles - 1) acc_last = 1'b1;
               t++;
               seen = 1'b0;
            end
         end else begin
            buf_write_ready = 1'b0;
         end
         @(negedge clk);
         start = 1'b0;
      end
      buf_write_ready = 1'b0;
      check("tile_count", 256'(t), 256'(v.tiles));
      check("beat_count", 256'(req_idx), 256'(v.beats));
      exp_stall = ((stall_tile >= 0) && (stall_tile < v.tiles)) ? stall_cycles : 0;
`ifdef LOAD_EXEC_PERF_EN
      check("perf_busy", 256'(perf_busy_cycles), 256'(busy_cnt));
      check("perf_stall", 256'(perf_stall_cycles), 256'(exp_stall));
`else
      check("perf_tied", 256'({perf_busy_cycles, perf_stall_cycles}), 256'(0));
`endif
      @(negedge clk);
      check("done_one_cycle", 256'(done), 256'(0));
      $display("[TB] cmd op=%h n=%0d tiles=%0d beats=%0d busy_cycles=%0d stall=%0d",
               v.op, v.n, t, req_idx, busy_cnt, exp_stall);
   endtask

   vec_t vecs[8];
   vec_t vs;

   initial begin : main
      //          op     len     rows    base          bid    n    beats tiles err
      vecs[0] = '{5'h01, 10'd32, 10'd0,  24'h000100,  5'd3,  32,  4,    1,    1'b0};
      vecs[1] = '{5'h01, 10'd40, 10'd0,  24'h000200,  5'd5,  40,  5,    2,    1'b0};
      vecs[2] = '{5'h02, 10'd20, 10'd3,  24'h001000,  5'd7,  60,  8,    2,    1'b0};
      vecs[3] = '{5'h01, 10'd17, 10'd9,  24'hFFFFF8,  5'd1,  17,  3,    1,    1'b0};
      vecs[4] = '{5'h03, 10'd32, 10'd0,  24'h000100,  5'd2,  0,   0,    0,    1'b1};
      vecs[5] = '{5'h01, 10'd0,  10'd0,  24'h000100,  5'd4,  0,   0,    0,    1'b1};
      vecs[6] = '{5'h02, 10'd40, 10'd4,  24'h00ABC0,  5'd30, 160, 20,   5,    1'b0};
      vecs[7] = '{5'h02, 10'd5,  10'd0,  24'h000300,  5'd6,  0,   0,    0,    1'b1};

      // Reset state.
      @(negedge clk);
      @(negedge clk);
      check("reset_ctrl", 256'({busy, done, error, mem_req_valid, mem_req_addr, buf_write_valid,
                                buf_write_is_matrix, buf_write_buffer_id, buf_write_last}), 256'(0));
      check("reset_tile", buf_write_tile, 256'(0));
      check("reset_perf", 256'({perf_busy_cycles, perf_stall_cycles}), 256'(0));
      rst = 1'b0;

      for (int i = 0; i < 8; i++) run_cmd(vecs[i], -1, 0, 1'b0);

      // Backpressure: ready held low 5 EMIT cycles, plus a start pulse while busy.
      vs = '{5'h01, 10'd32, 10'd0, 24'h000400, 5'd9, 32, 4, 1, 1'b0};
      run_cmd(vs, 0, 5, 1'b1);

      // Reset in the middle of a LOAD_M, then stale beats, then a fresh LOAD_V.
      exp_base = 24'h002000;
      req_idx  = 0;
      @(negedge clk);
      start = 1'b1; opcode = 5'h02; dest_buffer_id = 5'd12;
      length_or_cols = 10'd20; rows = 10'd3; addr = 24'h002000;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 6; i++) @(negedge clk);
      #1 rst = 1'b1;
      #1 check("midreset_outputs", 256'({busy, done, mem_req_valid, buf_write_valid}), 256'(0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      stale_inject = 2;
      begin
         bit quiet;
         quiet = 1'b1;
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || busy || mem_req_valid || buf_write_valid) quiet = 1'b0;
         end
         check("stale_ignored", 256'(quiet), 256'(1'b1));
      end
      $display("[TB] reset mid-command, stale beats injected");
      vs = '{5'h01, 10'd32, 10'd0, 24'h000500, 5'd11, 32, 4, 1, 1'b0};
      run_cmd(vs, -1, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
